// File: rtl/timer_pkg.sv
// Shared types and defaults for the countdown timer block.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts enabled cycles and flags the last cycle of each CLK_DIV period.
module tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] presc;

    // Tick only while enabled, so a held prescaler at LAST never fires on its own.
    assign tick = en && (presc == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
        end else if (clr) begin
            presc <= '0;
        end else if (en) begin
            presc <= tick ? '0 : presc + PW'(1);
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Loadable countdown timer with start/stop/clear control and a one-shot expiry pulse.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int CLK_DIV = 100000,
    parameter int WIDTH   = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             expired,
    output logic             done
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             done_nxt;
    logic             can_start;
    logic             pre_clr;
    logic             pre_en;
    logic             tick;

    assign can_start = start && (state == IDLE || state == PAUSED) && (count != '0);
    assign pre_clr   = clear || load || can_start;
    // Higher-priority controls and stop all freeze the prescaler, discarding a coincident tick.
    assign pre_en    = (state == RUNNING) && !clear && !load && !stop;

    tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .en  (pre_en),
        .clr (pre_clr),
        .tick(tick)
    );

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        done_nxt  = 1'b0;
        if (clear) begin
            state_nxt = IDLE;
            count_nxt = '0;
        end else if (load) begin
            state_nxt = IDLE;
            count_nxt = load_value;
        end else if (can_start) begin
            state_nxt = RUNNING;
        end else if (state == RUNNING && stop) begin
            state_nxt = PAUSED;
        end else if (state == RUNNING && tick) begin
            count_nxt = count - WIDTH'(1);
            if (count == WIDTH'(1)) begin
                state_nxt = EXPIRED;
                done_nxt  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            done  <= done_nxt;
        end
    end

    assign running = (state == RUNNING);
    assign expired = (state == EXPIRED);

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench: driver pushes model predictions, monitor compares DUT outputs after each edge.
module tb_countdown_timer;

    localparam int CLK_DIV = 4;
    localparam int WIDTH   = 32;

    typedef struct {
        int          step;
        logic [31:0] count;
        logic        running;
        logic        done;
        logic        expired;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst, load, start, stop, clear;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] count;
    logic             running, expired, done;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    // Reference model: mode codes 0=idle 1=counting 2=paused 3=expired.
    int          m_mode = 0;
    longint      m_count = 0;
    int          m_elapsed = 0;
    logic        m_done = 1'b0;

    always #5 clk = ~clk;

    countdown_timer #(
        .CLK_DIV(CLK_DIV),
        .WIDTH  (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_value(load_value),
        .start     (start),
        .stop      (stop),
        .clear     (clear),
        .count     (count),
        .running   (running),
        .expired   (expired),
        .done      (done)
    );

    task automatic model_step(input logic r, input logic c, input logic l, input logic [31:0] lv,
                              input logic s, input logic p);
        m_done = 1'b0;
        if (r) begin
            m_mode = 0; m_count = 0; m_elapsed = 0;
        end else if (c) begin
            m_mode = 0; m_count = 0; m_elapsed = 0;
        end else if (l) begin
            m_mode = 0; m_count = lv; m_elapsed = 0;
        end else if (s && (m_mode == 0 || m_mode == 2) && m_count != 0) begin
            m_mode = 1; m_elapsed = 0;
        end else if (m_mode == 1 && p) begin
            m_mode = 2;
        end else if (m_mode == 1) begin
            m_elapsed++;
            if (m_elapsed == CLK_DIV) begin
                m_elapsed = 0;
                m_count--;
                if (m_count == 0) begin
                    m_mode = 3;
                    m_done = 1'b1;
                end
            end
        end
    endtask

    task automatic drive(input logic r, input logic c, input logic l, input logic [31:0] lv,
                         input logic s, input logic p);
        exp_t e;
        @(negedge clk);
        rst = r; clear = c; load = l; load_value = lv; start = s; stop = p;
        model_step(r, c, l, lv, s, p);
        step_no++;
        e.step    = step_no;
        e.count   = m_count[31:0];
        e.running = (m_mode == 1);
        e.done    = m_done;
        e.expired = (m_mode == 3);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (count !== e.count || running !== e.running || done !== e.done || expired !== e.expired) begin
                    errors++;
                    $display("FAIL step%0d: got count=%0d running=%0b done=%0b expired=%0b, want count=%0d running=%0b done=%0b expired=%0b",
                             e.step, count, running, done, expired, e.count, e.running, e.done, e.expired);
                end
            end
        end
    end

    initial begin : stim
        rst = 1'b1; clear = 0; load = 0; load_value = 0; start = 0; stop = 0;
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        idle(2);
        // Load 3 and run to expiry
        drive(0, 0, 1, 3, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        idle(14);
        // Pause mid-countdown then resume
        drive(0, 0, 1, 5, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        idle(5);
        drive(0, 0, 0, 0, 0, 1);
        idle(13);
        drive(0, 0, 0, 0, 1, 0);
        idle(25);
        // Start with zero count is ignored
        drive(0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        idle(5);
        // load and clear together while counting at 7
        drive(0, 0, 1, 10, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        idle(12);
        drive(0, 1, 1, 5, 0, 0);
        idle(3);
        // Start ignored in expired, then reload 2
        drive(0, 0, 1, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        idle(6);
        drive(0, 0, 0, 0, 1, 0);
        idle(2);
        drive(0, 0, 1, 2, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        idle(10);
        // Reset at count 9 mid-run
        drive(0, 0, 1, 12, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        idle(12);
        drive(1, 0, 0, 0, 0, 0);
        idle(6);
        // Tick coinciding with stop: pause exactly on the tick cycle, then resume
        drive(0, 0, 1, 4, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        idle(3);
        drive(0, 0, 0, 0, 0, 1);
        idle(3);
        drive(0, 0, 0, 0, 1, 0);
        idle(18);
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 127) == 0),
                  ($urandom_range(0, 47) == 0),
                  ($urandom_range(0, 19) == 0),
                  32'($urandom_range(0, 6)),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 11) == 0));
        end
        idle(4);
        repeat (2) @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d predictions left unchecked, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
